cmp_sar_search: RTL and testbench

CMP_SAR_SEARCH -- requirements
Module: cmp_sar_search

---
 rtl/cmp_pkg.sv | 15 +
 rtl/cmp.sv | 23 ++
 rtl/cmp_sar_search.sv | 157 +++++++++++++++
 tb/tb_cmp_sar_search.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared width constant and SAR search state encoding
// Used by the magnitude comparator (cmp) and the SAR search block (cmp_sar_search).
package cmp_pkg;

    // Default operand width shared by the comparator and the search block.
    localparam int CMP_W = 8;

    // Search FSM state encoding.
    typedef logic [1:0] cmp_state_t;

    localparam cmp_state_t ST_IDLE = 2'd0;
    localparam cmp_state_t ST_CMP  = 2'd1;
    localparam cmp_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/cmp.sv
// rtl/cmp.sv - combinational unsigned magnitude comparator
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   gt   : a > b
//   lt   : a < b
//   eq   : a == b
module cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/cmp_sar_search.sv
// rtl/cmp_sar_search.sv - binary (SAR) search of a hidden target via an external comparator
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a new search (accepted in IDLE or DONE only)
//   guess         : registered operand for the external comparator's a port
//   gt, lt, eq    : comparator flags for guess vs target
//   busy          : high while compares are in progress
//   done          : one-cycle pulse when a search ends
//   found, err    : search outcome, valid from done onward
//   result        : matching guess when found, else 0
//   steps         : number of compares performed
module cmp_sar_search
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       steps
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    cmp_state_t       state_q,  state_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] guess_q,  guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       steps_q,  steps_d;
    logic             found_q,  found_d;
    logic             err_q,    err_d;
    logic             done_q,   done_d;

    // Midpoint evaluated one bit wider so lo+hi never overflows.
    function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] l,
                                                  input logic [WIDTH-1:0] h);
        logic [WIDTH:0] sum;
        sum = {1'b0, l} + {1'b0, h};
        return sum[WIDTH:1];
    endfunction

    logic             one_hot;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH-1:0] hi_nxt;

    assign one_hot = ({gt, lt, eq} == 3'b100) ||
                     ({gt, lt, eq} == 3'b010) ||
                     ({gt, lt, eq} == 3'b001);

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        steps_d  = steps_q;
        found_d  = found_q;
        err_d    = err_q;
        done_d   = 1'b0;
        lo_nxt   = guess_q + 1'b1;
        hi_nxt   = guess_q - 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = ALL_ONES;
                    guess_d  = midpoint('0, ALL_ONES);
                    steps_d  = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    state_d  = ST_CMP;
                end
            end
            ST_CMP: begin
                // Saturate so the count can never wrap.
                steps_d = (steps_q == 4'hF) ? steps_q : steps_q + 4'd1;
                if (!one_hot) begin
                    err_d   = 1'b1;
                    found_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (eq) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (gt) begin
                    // Guess too high: new upper bound below it; guess==0 has nowhere to go.
                    if (guess_q == '0 || lo_q > hi_nxt) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        hi_d    = hi_nxt;
                        guess_d = midpoint(lo_q, hi_nxt);
                    end
                end else begin
                    // Guess too low: new lower bound above it; all-ones has nowhere to go.
                    if (guess_q == ALL_ONES || lo_nxt > hi_q) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        lo_d    = lo_nxt;
                        guess_d = midpoint(lo_nxt, hi_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= ALL_ONES;
            guess_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            found_q  <= found_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = (state_q == ST_CMP);
    assign done   = done_q;
    assign found  = found_q;
    assign err    = err_q;
    assign result = result_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_cmp_sar_search.sv
// tb/tb_cmp_sar_search.sv - directed self-checking bench for cmp_sar_search with cmp in the loop
module tb_cmp_sar_search;
    import cmp_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] target = 8'h00;
    logic [7:0] guess;
    logic       c_gt, c_lt, c_eq;
    logic       gt, lt, eq;
    logic       busy, done, found, err;
    logic [7:0] result;
    logic [3:0] steps;

    logic       force_en = 1'b0;
    logic [2:0] force_flags = 3'b000;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] gseq [16];
    int         n_g;
    int         done_cyc;

    always #5 clk = ~clk;

    cmp #(.WIDTH(8)) u_cmp (
        .a  (guess),
        .b  (target),
        .gt (c_gt),
        .lt (c_lt),
        .eq (c_eq)
    );

    assign {gt, lt, eq} = force_en ? force_flags : {c_gt, c_lt, c_eq};

    cmp_sar_search #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .guess  (guess),
        .gt     (gt),
        .lt     (lt),
        .eq     (eq),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .err    (err),
        .result (result),
        .steps  (steps)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, record every guess seen while busy, and stop when done appears.
    // hold_start keeps start high during CMP, which the block must ignore.
    task automatic do_search(input logic [7:0] tgt, input logic hold_start);
        target = tgt;
        n_g = 0;
        done_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                done_cyc = c;
                break;
            end
            if (busy && n_g < 16) begin
                gseq[n_g] = guess;
                n_g++;
            end
            start = hold_start;
        end
        start = 1'b0;
        check("done_seen", (done_cyc != 0), 1);
    endtask

    task automatic check_seq(input string tag, input logic [71:0] v, input int n);
        check({tag, "_len"}, n_g, n);
        for (int i = 0; i < n && i < n_g; i++)
            check(tag, gseq[i], v[71-8*i -: 8]);
    endtask

    task automatic check_result(input string tag, input logic f, input logic e,
                                input logic [7:0] r, input logic [3:0] s);
        check({tag, "_found"},  found,  f);
        check({tag, "_err"},    err,    e);
        check({tag, "_result"}, result, r);
        check({tag, "_steps"},  steps,  s);
        check({tag, "_busy"},   busy,   0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_guess"},  guess,  0);
        check({tag, "_busy"},   busy,   0);
        check({tag, "_done"},   done,   0);
        check({tag, "_found"},  found,  0);
        check({tag, "_err"},    err,    0);
        check({tag, "_result"}, result, 0);
        check({tag, "_steps"},  steps,  0);
    endtask

    initial begin
        #12;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-compare hit at the first midpoint.
        do_search(8'h7F, 1'b0);
        check_seq("t7f_seq", {8'h7F, 64'h0}, 1);
        check("t7f_done_cyc", done_cyc, 2);
        check_result("t7f", 1, 0, 8'h7F, 4'd1);
        @(negedge clk);
        check("t7f_done_pulse", done, 0);
        check("t7f_guess_hold", guess, 8'h7F);

        // Seven descending compares, started from DONE.
        do_search(8'h01, 1'b0);
        check_seq("t01_seq", {8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 16'h0}, 7);
        check("t01_done_cyc", done_cyc, 8);
        check_result("t01", 1, 0, 8'h01, 4'd7);

        // Maximum-length search, with start held high during CMP.
        do_search(8'hFF, 1'b1);
        check_seq("tff_seq", {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF}, 9);
        check("tff_done_cyc", done_cyc, 10);
        check_result("tff", 1, 0, 8'hFF, 4'd9);

        // Lower boundary.
        do_search(8'h00, 1'b0);
        check_seq("t00_seq", {8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00}, 8);
        check_result("t00", 1, 0, 8'h00, 4'd8);

        // Illegal flags: two set.
        force_en = 1'b1;
        force_flags = 3'b110;
        do_search(8'h55, 1'b0);
        check("gtlt_done_cyc", done_cyc, 2);
        check_result("gtlt", 0, 1, 8'h00, 4'd1);

        // Illegal flags: none set.
        force_flags = 3'b000;
        do_search(8'h55, 1'b0);
        check("none_done_cyc", done_cyc, 2);
        check_result("none", 0, 1, 8'h00, 4'd1);
        force_en = 1'b0;

        // Reset during compare 3 of target 0x01.
        target = 8'h01;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_guess", guess, 8'h1F);
        #1 rst_n = 1'b0;
        #1;
        check_idle_zero("rst_mid");
        done_cyc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) done_cyc++;
        end
        check("rst_no_done", done_cyc, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("rst_rel");

        do_search(8'h01, 1'b0);
        check_seq("rst_t01_seq", {8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 16'h0}, 7);
        check_result("rst_t01", 1, 0, 8'h01, 4'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
